// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/terminal-count controller wrapped around a T-flip-flop up-counter.
// Optional tick prescaler is built in when COUNT_SEQ_PRESCALE_EN is defined.
module count_sequencer #(
    parameter int N          = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  auto_rld,
    input  logic [N-1:0]          limit,
`ifdef COUNT_SEQ_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [N-1:0]          count,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [N-1:0] r_count, r_limit_q, w_toggle;
    logic         r_auto_q, r_busy, r_done;
    logic         w_busy_nxt, w_done_nxt;
    logic         w_tick, w_start_new, w_adv, w_hit, w_zero, w_inc;

    assign w_start_new = start & ~pause & ~clear & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_adv       = (r_state == S_RUN) & w_tick & ~pause & ~clear;
    assign w_hit       = w_adv & (r_count == r_limit_q);
    assign w_zero      = clear | w_start_new | (w_hit & r_auto_q);
    assign w_inc       = w_adv & ~w_hit;

`ifdef COUNT_SEQ_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_pre;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (clear | w_start_new) begin
            r_pre <= prescale;
        end else if ((r_state == S_RUN) & ~pause) begin
            r_pre <= w_tick ? prescale : r_pre - 1'b1;
        end
    end

    assign w_tick = (r_pre == '0);
`else
    // Without a divider the tick is a permanent divide-by-one.
    localparam logic [PRESCALE_W-1:0] P_DIV_ONE = '0;
    assign w_tick = (P_DIV_ONE == '0);
`endif

    // Each T stage toggles on the AND of all lower stages; forcing to zero toggles every set bit.
    always_comb begin
        logic w_chain;
        w_toggle = '0;
        w_chain  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (w_zero) begin
                w_toggle[i] = r_count[i];
            end else begin
                w_toggle[i] = w_inc & w_chain;
            end
            w_chain = w_chain & r_count[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = w_hit;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start & ~pause) w_state_nxt = S_RUN;
                S_RUN: begin
                    if (pause)                   w_state_nxt = S_PAUSE;
                    else if (w_hit & ~r_auto_q)  w_state_nxt = S_DONE;
                end
                S_PAUSE: if (start & ~pause) w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_busy_nxt = (w_state_nxt == S_RUN) | (w_state_nxt == S_PAUSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count ^ w_toggle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_limit_q <= '0;
            r_auto_q  <= 1'b0;
        end else if (w_start_new) begin
            r_limit_q <= limit;
            r_auto_q  <= auto_rld;
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign state = r_state;
endmodule
